// File: rtl/ysyx_24100029_pred_check.sv
// Branch-prediction checker: queues BPU predictions in program order, compares them
// against resolved outcomes, raises flush/redirect on mispredict and drives BPU updates.
module ysyx_24100029_pred_check #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_npc,
    input  logic             push_taken,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [31:0]      res_pc,
    input  logic             res_is_br,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             br_valid,
    output logic             br_is_taken,
    output logic [31:0]      br_pc,
    output logic [31:0]      br_npc,
    output logic             order_err,
    output logic [CNT_W-1:0] stat_br,
    output logic [CNT_W-1:0] stat_miss
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_r, state_nx;
    logic [PTR_W-1:0]   wptr_r, wptr_nx;
    logic [PTR_W-1:0]   rptr_r, rptr_nx;
    logic [PTR_W:0]     count_r, count_nx;

    logic [31:0]        pc_q  [DEPTH];
    logic [31:0]        npc_q [DEPTH];
    logic               tk_q  [DEPTH];

    logic               push_ready_r, res_ready_r;
    logic               flush_r;
    logic [31:0]        redirect_pc_r;
    logic               br_valid_r, br_is_taken_r;
    logic [31:0]        br_pc_r, br_npc_r;
    logic               order_err_r;
    logic [CNT_W-1:0]   stat_br_r, stat_miss_r;

    logic               push_fire_s, res_fire_s;
    logic [31:0]        actual_s;
    logic               miss_s;

    assign push_fire_s = push_valid && push_ready_r;
    assign res_fire_s  = res_valid && res_ready_r;
    assign actual_s    = (res_is_br && res_taken) ? res_target : (res_pc + 32'd4);
    // A non-branch predicted taken is wrong even if its npc happens to be pc+4.
    assign miss_s      = res_fire_s &&
                         ((actual_s != npc_q[rptr_r]) || (!res_is_br && tk_q[rptr_r]));

    // Next-state, pointer and occupancy computation.
    always_comb begin
        state_nx = state_r;
        wptr_nx  = wptr_r;
        rptr_nx  = rptr_r;
        count_nx = count_r;
        case (state_r)
            ST_RUN: begin
                if (miss_s) begin
                    state_nx = ST_FLUSH;
                    wptr_nx  = {PTR_W{1'b0}};
                    rptr_nx  = {PTR_W{1'b0}};
                    count_nx = {(PTR_W + 1){1'b0}};
                end else begin
                    if (push_fire_s) wptr_nx = wptr_r + PTR_W'(1);
                    else             wptr_nx = wptr_r;
                    if (res_fire_s)  rptr_nx = rptr_r + PTR_W'(1);
                    else             rptr_nx = rptr_r;
                    if (push_fire_s && !res_fire_s)      count_nx = count_r + (PTR_W + 1)'(1);
                    else if (!push_fire_s && res_fire_s) count_nx = count_r - (PTR_W + 1)'(1);
                    else                                 count_nx = count_r;
                end
            end
            ST_FLUSH: begin
                state_nx = ST_RUN;
            end
            default: begin
                state_nx = ST_RUN;
                wptr_nx  = {PTR_W{1'b0}};
                rptr_nx  = {PTR_W{1'b0}};
                count_nx = {(PTR_W + 1){1'b0}};
            end
        endcase
    end

    // Prediction storage; wrong-path writes are harmless since pointers get cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= 32'd0;
                npc_q[i] <= 32'd0;
                tk_q[i]  <= 1'b0;
            end
        end else if (push_fire_s) begin
            pc_q[wptr_r]  <= push_pc;
            npc_q[wptr_r] <= push_npc;
            tk_q[wptr_r]  <= push_taken;
        end
    end

    // Control state, handshakes, flush/redirect, BPU update and statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_RUN;
            wptr_r        <= {PTR_W{1'b0}};
            rptr_r        <= {PTR_W{1'b0}};
            count_r       <= {(PTR_W + 1){1'b0}};
            push_ready_r  <= 1'b0;
            res_ready_r   <= 1'b0;
            flush_r       <= 1'b0;
            redirect_pc_r <= 32'd0;
            br_valid_r    <= 1'b0;
            br_is_taken_r <= 1'b0;
            br_pc_r       <= 32'd0;
            br_npc_r      <= 32'd0;
            order_err_r   <= 1'b0;
            stat_br_r     <= {CNT_W{1'b0}};
            stat_miss_r   <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nx;
            wptr_r       <= wptr_nx;
            rptr_r       <= rptr_nx;
            count_r      <= count_nx;
            push_ready_r <= (state_nx == ST_RUN) && (count_nx < FULL_CNT);
            res_ready_r  <= (state_nx == ST_RUN) && (count_nx != {(PTR_W + 1){1'b0}});

            flush_r       <= miss_s;
            br_valid_r    <= res_fire_s && res_is_br;
            br_is_taken_r <= (res_fire_s && res_is_br) ? res_taken  : 1'b0;
            br_pc_r       <= (res_fire_s && res_is_br) ? res_pc     : 32'd0;
            br_npc_r      <= (res_fire_s && res_is_br) ? res_target : 32'd0;

            if (miss_s) begin
                redirect_pc_r <= actual_s;
                stat_miss_r   <= stat_miss_r + CNT_W'(1);
            end
            if (res_fire_s && res_is_br) begin
                stat_br_r <= stat_br_r + CNT_W'(1);
            end
            if (res_fire_s && (res_pc != pc_q[rptr_r])) begin
                order_err_r <= 1'b1;
            end
        end
    end

    assign push_ready  = push_ready_r;
    assign res_ready   = res_ready_r;
    assign flush       = flush_r;
    assign redirect_pc = redirect_pc_r;
    assign br_valid    = br_valid_r;
    assign br_is_taken = br_is_taken_r;
    assign br_pc       = br_pc_r;
    assign br_npc      = br_npc_r;
    assign order_err   = order_err_r;
    assign stat_br     = stat_br_r;
    assign stat_miss   = stat_miss_r;

endmodule

// File: tb/tb_ysyx_24100029_pred_check.sv
// Bench for ysyx_24100029_pred_check: queue-based reference model checked every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_ysyx_24100029_pred_check;

    localparam int DEPTH = 4;

    logic        clock, reset;
    logic        push_valid, push_ready, push_taken;
    logic [31:0] push_pc, push_npc;
    logic        res_valid, res_ready, res_is_br, res_taken;
    logic [31:0] res_pc, res_target;
    logic        flush, br_valid, br_is_taken, order_err;
    logic [31:0] redirect_pc, br_pc, br_npc, stat_br, stat_miss;

    int n_cmp = 0;
    int n_fail = 0;

    ysyx_24100029_pred_check #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_npc(push_npc), .push_taken(push_taken),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_is_br(res_is_br), .res_taken(res_taken), .res_target(res_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .br_valid(br_valid), .br_is_taken(br_is_taken), .br_pc(br_pc), .br_npc(br_npc),
        .order_err(order_err), .stat_br(stat_br), .stat_miss(stat_miss)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        tk;
    } ent_t;

    ent_t        q[$];
    ent_t        h;
    bit          live = 1'b0, in_flush = 1'b0;
    bit          m_flush = 1'b0, m_brv = 1'b0, m_brt = 1'b0, m_order = 1'b0;
    logic [31:0] m_redirect = 32'd0, m_brpc = 32'd0, m_brnpc = 32'd0;
    logic [31:0] m_sbr = 32'd0, m_smiss = 32'd0;
    bit          pr, rr, miss;
    logic [31:0] act;
    bit          prev_flush = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            live = 1'b0; in_flush = 1'b0;
            m_flush = 1'b0; m_brv = 1'b0; m_brt = 1'b0; m_order = 1'b0;
            m_redirect = 32'd0; m_brpc = 32'd0; m_brnpc = 32'd0;
            m_sbr = 32'd0; m_smiss = 32'd0;
        end else begin
            pr = live && !in_flush && (q.size() < DEPTH);
            rr = live && !in_flush && (q.size() > 0);
            miss = 1'b0;
            m_flush = 1'b0;
            m_brv = 1'b0; m_brt = 1'b0; m_brpc = 32'd0; m_brnpc = 32'd0;
            in_flush = 1'b0;
            if (res_valid && rr) begin
                h = q.pop_front();
                act = (res_is_br && res_taken) ? res_target : res_pc + 32'd4;
                miss = (act != h.npc) || (!res_is_br && h.tk);
                if (res_pc != h.pc) m_order = 1'b1;
                if (res_is_br) begin
                    m_brv = 1'b1; m_brt = res_taken; m_brpc = res_pc; m_brnpc = res_target;
                    m_sbr = m_sbr + 32'd1;
                end
                if (miss) begin
                    m_flush = 1'b1; m_redirect = act; m_smiss = m_smiss + 32'd1; in_flush = 1'b1;
                end
            end
            if (push_valid && pr && !miss) q.push_back('{pc: push_pc, npc: push_npc, tk: push_taken});
            if (miss) q.delete();
            live = 1'b1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        chk("push_ready", {31'd0, push_ready}, {31'd0, live && !in_flush && (q.size() < DEPTH)});
        chk("res_ready",  {31'd0, res_ready},  {31'd0, live && !in_flush && (q.size() > 0)});
        chk("flush",      {31'd0, flush},      {31'd0, m_flush});
        if (m_flush) chk("redirect_pc", redirect_pc, m_redirect);
        chk("br_valid",   {31'd0, br_valid},   {31'd0, m_brv});
        if (m_brv) begin
            chk("br_is_taken", {31'd0, br_is_taken}, {31'd0, m_brt});
            chk("br_pc",       br_pc,  m_brpc);
            chk("br_npc",      br_npc, m_brnpc);
        end
        chk("order_err",  {31'd0, order_err},  {31'd0, m_order});
        chk("stat_br",    stat_br,   m_sbr);
        chk("stat_miss",  stat_miss, m_smiss);
        if (prev_flush) chk("flush_twice", {31'd0, flush}, 32'd0);
        prev_flush = flush;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_push(input logic [31:0] pc, input logic [31:0] npc, input logic tk);
        push_valid = 1'b1; push_pc = pc; push_npc = npc; push_taken = tk;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic do_res(input logic [31:0] pc, input logic isbr, input logic tk,
                          input logic [31:0] tgt);
        res_valid = 1'b1; res_pc = pc; res_is_br = isbr; res_taken = tk; res_target = tgt;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        push_valid = 1'b0; push_pc = 32'd0; push_npc = 32'd0; push_taken = 1'b0;
        res_valid = 1'b0; res_pc = 32'd0; res_is_br = 1'b0; res_taken = 1'b0; res_target = 32'd0;
        tick(); tick();
        chk("rst_push_ready", {31'd0, push_ready}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_stat_br", stat_br, 32'd0);
        reset = 1'b1;
        tick();
        chk("run_push_ready", {31'd0, push_ready}, 32'd1);
        chk("run_res_ready", {31'd0, res_ready}, 32'd0);

        // Non-branch, correctly predicted sequential.
        do_push(32'h8000_0000, 32'h8000_0004, 1'b0);
        do_res(32'h8000_0000, 1'b0, 1'b0, 32'h0);
        chk("t1_flush", {31'd0, flush}, 32'd0);
        chk("t1_br_valid", {31'd0, br_valid}, 32'd0);
        chk("t1_stat_br", stat_br, 32'd0);
        chk("t1_res_ready", {31'd0, res_ready}, 32'd0);

        // Taken branch, correctly predicted.
        do_push(32'h8000_0010, 32'h8000_0040, 1'b1);
        do_res(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0040);
        chk("t2_br_valid", {31'd0, br_valid}, 32'd1);
        chk("t2_br_pc", br_pc, 32'h8000_0010);
        chk("t2_br_npc", br_npc, 32'h8000_0040);
        chk("t2_br_taken", {31'd0, br_is_taken}, 32'd1);
        chk("t2_flush", {31'd0, flush}, 32'd0);
        chk("t2_stat_br", stat_br, 32'd1);

        // Branch predicted not-taken, actually taken.
        do_push(32'h8000_0020, 32'h8000_0024, 1'b0);
        do_res(32'h8000_0020, 1'b1, 1'b1, 32'h8000_0100);
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_redirect", redirect_pc, 32'h8000_0100);
        chk("t3_stat_miss", stat_miss, 32'd1);
        chk("t3_push_ready", {31'd0, push_ready}, 32'd0);
        tick();
        chk("t3_flush_off", {31'd0, flush}, 32'd0);
        chk("t3_push_ready_back", {31'd0, push_ready}, 32'd1);

        // Fill to full, refused push alongside a resolve, drain across the wrap.
        for (int i = 0; i < 4; i++) do_push(32'h0000_00A0 + 32'(i * 4), 32'h0000_00A4 + 32'(i * 4), 1'b0);
        chk("t4_full", {31'd0, push_ready}, 32'd0);
        push_valid = 1'b1; push_pc = 32'h0000_00B0; push_npc = 32'h0000_00B4; push_taken = 1'b0;
        do_res(32'h0000_00A0, 1'b0, 1'b0, 32'h0);
        push_valid = 1'b0;
        chk("t4_after_refuse", {31'd0, push_ready}, 32'd1);
        for (int i = 1; i < 4; i++) do_res(32'h0000_00A0 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
        chk("t4_empty", {31'd0, res_ready}, 32'd0);
        chk("t4_no_miss", stat_miss, 32'd1);
        do_push(32'h0000_00B0, 32'h0000_00B4, 1'b0);
        do_res(32'h0000_00B0, 1'b0, 1'b0, 32'h0);

        // Mispredict on head of a 3-entry queue with a concurrent push.
        for (int i = 0; i < 3; i++) do_push(32'h0000_00C0 + 32'(i * 4), 32'h0000_00C4 + 32'(i * 4), 1'b0);
        push_valid = 1'b1; push_pc = 32'h0000_00CC; push_npc = 32'h0000_00D0; push_taken = 1'b0;
        do_res(32'h0000_00C0, 1'b1, 1'b1, 32'h0000_0200);
        push_valid = 1'b0;
        chk("t5_flush", {31'd0, flush}, 32'd1);
        chk("t5_redirect", redirect_pc, 32'h0000_0200);
        tick();
        chk("t5_empty", {31'd0, res_ready}, 32'd0);
        do_res(32'h0000_00C4, 1'b0, 1'b0, 32'h0);
        chk("t5_refused", {31'd0, res_ready}, 32'd0);
        chk("t5_miss_cnt", stat_miss, 32'd2);
        do_push(32'h0000_00D0, 32'h0000_00D4, 1'b0);
        do_res(32'h0000_00D0, 1'b0, 1'b0, 32'h0);

        // Non-branch predicted taken with a sequential npc is still a mispredict.
        do_push(32'h0000_00E0, 32'h0000_00E4, 1'b1);
        do_res(32'h0000_00E0, 1'b0, 1'b0, 32'h0);
        chk("t6_flush", {31'd0, flush}, 32'd1);
        chk("t6_redirect", redirect_pc, 32'h0000_00E4);
        tick();

        // pc+4 wraps to zero.
        do_push(32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
        do_res(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        chk("t7_wrap_no_flush", {31'd0, flush}, 32'd0);

        // Order error is sticky.
        do_push(32'h8000_0000, 32'h0000_1238, 1'b0);
        do_res(32'h0000_1234, 1'b0, 1'b0, 32'h0);
        chk("t8_order", {31'd0, order_err}, 32'd1);
        tick(); tick();
        chk("t8_order_sticky", {31'd0, order_err}, 32'd1);

        // Reset pulled low during a FLUSH cycle clears everything at once.
        do_push(32'h0000_0300, 32'h0000_0304, 1'b0);
        do_res(32'h0000_0300, 1'b1, 1'b1, 32'h0000_0400);
        chk("t9_in_flush", {31'd0, flush}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t9_rst_flush", {31'd0, flush}, 32'd0);
        chk("t9_rst_redirect", redirect_pc, 32'd0);
        chk("t9_rst_order", {31'd0, order_err}, 32'd0);
        chk("t9_rst_stat_br", stat_br, 32'd0);
        chk("t9_rst_stat_miss", stat_miss, 32'd0);
        chk("t9_rst_push_ready", {31'd0, push_ready}, 32'd0);
        tick();
        reset = 1'b1;
        tick(); tick();
        chk("t9_run_push_ready", {31'd0, push_ready}, 32'd1);
        chk("t9_run_res_ready", {31'd0, res_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
